hex_display_ctrl: RTL and testbench



---
 rtl/hex_display_ctrl.sv | 89 ++++++++
 tb/tb_hex_display_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Paged nibble feeder for the HEX 7-segment decoders: captures a 32-bit value, pages it by button or timer.
// Optional leading-zero blanking is built when HEX_DISPLAY_LEADING_ZERO_BLANK_EN is defined.
module hex_display_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [31:0]               data_in,
  input  logic                      load,
  input  logic                      page_btn,
  input  logic                      auto_en,
  output logic [4*NUM_DIGITS-1:0]   digit_nibbles,
  output logic [NUM_DIGITS-1:0]     digit_blank,
  output logic [2:0]                page_idx
);

  localparam int NUM_PAGES = 8 / NUM_DIGITS;
  localparam int LOG_D     = $clog2(NUM_DIGITS);
  localparam int CNT_W     = $clog2(AUTO_PERIOD);
  localparam logic [2:0]       LAST_PAGE = 3'(NUM_PAGES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(AUTO_PERIOD - 1);

  logic [31:0]      value_q, value_d;
  logic [2:0]       page_q, page_d;
  logic             btn_s1_q, btn_s2_q, btn_prev_q;
  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  logic             rise, tick;
  logic [4:0]       shift_bits;

  always_comb begin
    rise       = btn_s2_q & ~btn_prev_q;
    tick       = auto_en & (auto_cnt_q == LAST_CNT);
    value_d    = load ? data_in : value_q;
    // Disabling the timer parks the counter so re-enabling waits a full period.
    auto_cnt_d = (!auto_en || tick) ? '0 : auto_cnt_q + 1'b1;
    page_d     = page_q;
    if (rise | tick) begin
      page_d = (page_q == LAST_PAGE) ? 3'd0 : page_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      value_q    <= '0;
      page_q     <= '0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      value_q    <= value_d;
      page_q     <= page_d;
      btn_s1_q   <= page_btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      auto_cnt_q <= auto_cnt_d;
    end
  end

  // Bit offset of the current page inside value_q: page * NUM_DIGITS * 4.
  assign shift_bits    = 5'(page_q) << (LOG_D + 2);
  assign digit_nibbles = (4*NUM_DIGITS)'(value_q >> shift_bits);
  assign page_idx      = page_q;

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
  logic [2:0] msn;
  logic [3:0] page_base;

  always_comb begin
    msn = '0;
    for (int k = 0; k < 8; k++) begin
      if (value_q[4*k +: 4] != 4'd0) msn = 3'(k);
    end
  end

  assign page_base = 4'(page_q) << LOG_D;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign digit_blank[gi] = (page_base + 4'(gi)) > {1'b0, msn};
    end
  endgenerate
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed plan steps plus random traffic against a behavioural model.
module tb_hex_display_ctrl;

  logic        clock = 1'b0;
  logic        clear, load, page_btn, auto_en;
  logic [31:0] data_in;
  logic [15:0] nib4;
  logic [3:0]  blank4;
  logic [2:0]  pg4;
  logic [31:0] nib8;
  logic [7:0]  blank8;
  logic [2:0]  pg8;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: shown values/pages, consecutive enabled edges, button samples from past edges.
  logic [31:0] m_val4, m_val8;
  int          m_pg4, m_pg8, run;
  logic        h0, h1, h2;

  always #5 clock = ~clock;

  hex_display_ctrl #(.NUM_DIGITS(4), .AUTO_PERIOD(4)) dut4 (
    .clock(clock), .clear(clear), .data_in(data_in), .load(load), .page_btn(page_btn),
    .auto_en(auto_en), .digit_nibbles(nib4), .digit_blank(blank4), .page_idx(pg4));

  hex_display_ctrl #(.NUM_DIGITS(8), .AUTO_PERIOD(3)) dut8 (
    .clock(clock), .clear(clear), .data_in(data_in), .load(load), .page_btn(page_btn),
    .auto_en(auto_en), .digit_nibbles(nib8), .digit_blank(blank8), .page_idx(pg8));

  function automatic logic [31:0] exp_nib(input logic [31:0] v, input int pg, input int nd);
    logic [31:0] mask;
    mask = (nd == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4*nd)) - 32'h1);
    return (v >> (pg*nd*4)) & mask;
  endfunction

  function automatic logic [31:0] exp_blank(input logic [31:0] v, input int pg, input int nd);
    logic [31:0] r;
    int msn;
    r = '0;
    msn = 0;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    for (int k = 0; k < 8; k++) if (((v >> (4*k)) & 32'hF) != 32'h0) msn = k;
    for (int i = 0; i < nd; i++) if (pg*nd + i > msn) r[i] = 1'b1;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic rise, t4, t8;
    if (clear) begin
      m_val4 = '0; m_val8 = '0; m_pg4 = 0; m_pg8 = 0; run = 0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      rise = h1 && !h2;
      run  = auto_en ? run + 1 : 0;
      t4   = auto_en && (run % 4 == 0);
      t8   = auto_en && (run % 3 == 0);
      if (load) begin
        m_val4 = data_in;
        m_val8 = data_in;
      end
      if (rise || t4) m_pg4 = (m_pg4 + 1) % 2;
      if (rise || t8) m_pg8 = (m_pg8 + 1) % 1;
      h2 = h1; h1 = h0; h0 = page_btn;
    end
  endtask

  task automatic check_all();
    chk("d4_nib",   32'(nib4),   exp_nib(m_val4, m_pg4, 4));
    chk("d4_blank", 32'(blank4), exp_blank(m_val4, m_pg4, 4));
    chk("d4_page",  32'(pg4),    32'(m_pg4));
    chk("d8_nib",   nib8,        exp_nib(m_val8, m_pg8, 8));
    chk("d8_blank", 32'(blank8), exp_blank(m_val8, m_pg8, 8));
    chk("d8_page",  32'(pg8),    32'(m_pg8));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; page_btn = 1'b0; auto_en = 1'b0; data_in = '0;
    m_val4 = '0; m_val8 = '0; m_pg4 = 0; m_pg8 = 0; run = 0;
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    step(1);
    chk("reset_nib", 32'(nib4), 32'h0);
    chk("reset_page", 32'(pg4), 32'h0);
    chk("reset_blank", 32'(blank4), 32'h0);
    clear = 1'b0;

    load = 1'b1; data_in = 32'hDEADBEEF;
    step(1);
    load = 1'b0;
    chk("load_nib", 32'(nib4), 32'h0000BEEF);
    chk("load_page", 32'(pg4), 32'h0);

    // Button held: advance lands two edges after the first sampling edge, once only.
    page_btn = 1'b1;
    step(2);
    chk("btn_not_yet", 32'(pg4), 32'h0);
    step(1);
    chk("btn_page", 32'(pg4), 32'h1);
    chk("btn_nib", 32'(nib4), 32'h0000DEAD);
    step(7);
    chk("btn_held", 32'(pg4), 32'h1);
    page_btn = 1'b0;
    step(3);
    page_btn = 1'b1;
    step(3);
    chk("btn_wrap", 32'(pg4), 32'h0);
    page_btn = 1'b0;
    step(3);

    // Auto-scroll with period 4, then a disable gap restarting the period.
    auto_en = 1'b1;
    step(3);
    chk("auto_wait", 32'(pg4), 32'h0);
    step(1);
    chk("auto_tick1", 32'(pg4), 32'h1);
    step(4);
    chk("auto_tick2", 32'(pg4), 32'h0);
    auto_en = 1'b0;
    step(2);
    auto_en = 1'b1;
    step(3);
    chk("auto_restart_wait", 32'(pg4), 32'h0);
    step(1);
    chk("auto_restart_tick", 32'(pg4), 32'h1);

    // Button rise coincides with terminal count: one advance, counter restarts.
    step(1);
    page_btn = 1'b1;
    step(3);
    chk("collide_once", 32'(pg4), 32'h0);
    page_btn = 1'b0;
    step(3);
    chk("collide_cnt_wait", 32'(pg4), 32'h0);
    step(1);
    chk("collide_cnt_tick", 32'(pg4), 32'h1);
    auto_en = 1'b0;
    step(1);

    // Clear on the edge where rise is active.
    page_btn = 1'b1;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    page_btn = 1'b0;
    chk("clr_rise_page", 32'(pg4), 32'h0);
    chk("clr_rise_nib", 32'(nib4), 32'h0);
    step(3);

    // Load and advance on the same edge.
    page_btn = 1'b1;
    step(2);
    load = 1'b1; data_in = 32'h12345678;
    step(1);
    load = 1'b0;
    chk("ld_adv_nib", 32'(nib4), 32'h00001234);
    chk("ld_adv_page", 32'(pg4), 32'h1);
    page_btn = 1'b0;
    step(3);

    for (int it = 0; it < 400; it++) begin
      clear = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 3) == 0);
      data_in = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) page_btn = ~page_btn;
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      step(1);
    end

    clear = 1'b1; load = 1'b0; page_btn = 1'b0; auto_en = 1'b0;
    step(1);
    clear = 1'b0;
    load = 1'b1; data_in = 32'h000000A5;
    step(1);
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    chk("blank_a5", 32'(blank8), 32'h000000FC);
`else
    chk("blank_a5", 32'(blank8), 32'h0);
`endif
    chk("nib_a5", nib8, 32'h000000A5);
    data_in = 32'h0;
    step(1);
    load = 1'b0;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    chk("blank_zero", 32'(blank8), 32'h000000FE);
`else
    chk("blank_zero", 32'(blank8), 32'h0);
`endif
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
